// File: rtl/reg_serializer.sv
// Parallel-to-serial unloader: loads one WIDTH-bit word and streams it out
// bit by bit over a valid/ready link, with busy while shifting and a done pulse.
module reg_serializer #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_bit,
   output logic             out_last,
   output logic             busy,
   output logic             done
);

   localparam int unsigned    CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   sreg_q, sreg_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               done_q, done_d;
   logic               at_last;

   // Next-state: load in IDLE, shift or finish on each accepted bit in SHIFT
   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      at_last = (cnt_q == CNT_LAST);
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sreg_d  = in_data;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (out_ready) begin
               if (at_last) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  sreg_d = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
                  cnt_d  = cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // Outputs are forced quiet while reset is held, even mid-word
   assign busy      = (state_q == SHIFT) && !reset;
   assign in_ready  = (state_q == IDLE) && !reset;
   assign out_valid = busy;
   assign out_bit   = busy && (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]);
   assign out_last  = busy && (cnt_q == CNT_LAST);
   assign done      = done_q && !reset;

endmodule

// File: tb/tb_reg_serializer.sv
// Bench for reg_serializer: three instances (8-bit LSB/MSB first, 1-bit) checked
// against a word/remaining-bits reference model, plus a table of explicit vectors.
module tb_reg_serializer;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [7:0] din;
   logic       out_ready;

   logic [5:0] obs [3];  // {in_ready, out_valid, out_bit, out_last, busy, done}
   logic       ir  [3];
   logic       ov  [3];
   logic       ob  [3];
   logic       ol  [3];
   logic       bs  [3];
   logic       dn  [3];

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   int         wid [3] = '{8, 8, 1};
   bit         msb [3] = '{1'b0, 1'b1, 1'b0};
   int         rem [3] = '{0, 0, 0};
   logic [7:0] word [3];
   bit         dexp [3] = '{1'b0, 1'b0, 1'b0};

   always #5 clk = ~clk;

   reg_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]),
      .in_data(din), .out_valid(ov[0]), .out_ready(out_ready),
      .out_bit(ob[0]), .out_last(ol[0]), .busy(bs[0]), .done(dn[0]));

   reg_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]),
      .in_data(din), .out_valid(ov[1]), .out_ready(out_ready),
      .out_bit(ob[1]), .out_last(ol[1]), .busy(bs[1]), .done(dn[1]));

   reg_serializer #(.WIDTH(1), .MSB_FIRST(1'b0)) u_w1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]),
      .in_data(din[0:0]), .out_valid(ov[2]), .out_ready(out_ready),
      .out_bit(ob[2]), .out_last(ol[2]), .busy(bs[2]), .done(dn[2]));

   always_comb begin
      for (int i = 0; i < 3; i++)
         obs[i] = {ir[i], ov[i], ob[i], ol[i], bs[i], dn[i]};
   end

   // Expected outputs from the word in flight and how many bits remain to send
   function automatic logic [5:0] model_out(input int d, input logic rst);
      logic b, bv;
      int   pos, idx;
      b   = (rem[d] > 0) && !rst;
      pos = wid[d] - rem[d];
      idx = msb[d] ? (wid[d] - 1 - pos) : pos;
      bv  = b ? word[d][idx] : 1'b0;
      return {(rem[d] == 0) && !rst, b, bv, b && (rem[d] == 1), b, dexp[d] && !rst};
   endfunction

   task automatic model_edge(input logic rst, input logic iv, input logic [7:0] d_in,
                             input logic ordy);
      bit fin;
      for (int d = 0; d < 3; d++) begin
         if (rst) begin
            rem[d]  = 0;
            dexp[d] = 1'b0;
         end else begin
            fin = (rem[d] > 0) && ordy && (rem[d] == 1);
            if (rem[d] > 0 && ordy) rem[d] = rem[d] - 1;
            else if (rem[d] == 0 && iv) begin
               word[d] = d_in;
               rem[d]  = wid[d];
            end
            dexp[d] = fin;
         end
      end
   endtask

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got {rdy,vld,bit,last,busy,done}=%b expected %b",
                  name, $time, act, exp);
      end
   endtask

   // One clock: drive, check all instances against the model (and optionally
   // the 8-bit LSB instance against an explicit vector), then take the edge.
   task automatic cyc(input logic rst, input logic iv, input logic [7:0] d_in,
                      input logic ordy, input bit chk0, input logic [5:0] exp0,
                      input string tag);
      reset = rst; in_valid = iv; din = d_in; out_ready = ordy;
      #2;
      for (int d = 0; d < 3; d++)
         check($sformatf("%s/model%0d", tag, d), obs[d], model_out(d, rst));
      if (chk0) check($sformatf("%s/vec", tag), obs[0], exp0);
      @(posedge clk);
      model_edge(rst, iv, d_in, ordy);
      @(negedge clk);
   endtask

   typedef struct {
      logic       iv;
      logic [7:0] d;
      logic       ordy;
      logic [5:0] exp;
   } vec_t;

   vec_t tbl [10];

   initial begin
      // Load 0xC1, out_ready high: bits 1,0,0,0,0,0,1,1 then done with in_ready
      tbl[0] = '{1'b1, 8'hC1, 1'b1, 6'b100000};
      tbl[1] = '{1'b0, 8'h00, 1'b1, 6'b011010};
      tbl[2] = '{1'b0, 8'h00, 1'b1, 6'b010010};
      tbl[3] = '{1'b0, 8'h00, 1'b1, 6'b010010};
      tbl[4] = '{1'b0, 8'h00, 1'b1, 6'b010010};
      tbl[5] = '{1'b0, 8'h00, 1'b1, 6'b010010};
      tbl[6] = '{1'b0, 8'h00, 1'b1, 6'b010010};
      tbl[7] = '{1'b0, 8'h00, 1'b1, 6'b011010};
      tbl[8] = '{1'b0, 8'h00, 1'b1, 6'b011110};
      tbl[9] = '{1'b0, 8'h00, 1'b1, 6'b100001};

      reset = 1'b1; in_valid = 1'b0; din = 8'h00; out_ready = 1'b0;
      @(negedge clk);
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 6'b000000, "reset");
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 6'b100000, "idle");

      for (int i = 0; i < 10; i++)
         cyc(1'b0, tbl[i].iv, tbl[i].d, tbl[i].ordy, 1'b1, tbl[i].exp,
             $sformatf("c1_row%0d", i));

      // Backpressure: stall three cycles after the second bit
      cyc(1'b0, 1'b1, 8'hC1, 1'b1, 1'b1, 6'b100000, "bp_load");
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 6'b011010, "bp_b0");
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 6'b010010, "bp_b1");
      for (int i = 0; i < 3; i++)
         cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 6'b010010, $sformatf("bp_stall%0d", i));
      for (int i = 0; i < 6; i++)
         cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 6'b000000, $sformatf("bp_rest%0d", i));
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 6'b100001, "bp_done");

      // Busy collision: 0xFF held on the input the whole time
      cyc(1'b0, 1'b1, 8'hC1, 1'b1, 1'b1, 6'b100000, "col_load");
      for (int i = 0; i < 8; i++)
         cyc(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 6'b000000, $sformatf("col_shift%0d", i));
      cyc(1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 6'b100001, "col_done_load");
      for (int i = 0; i < 8; i++)
         cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, (i == 7) ? 6'b011110 : 6'b011010,
             $sformatf("col_ff%0d", i));
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 6'b100001, "col_ff_done");

      // Reset after the fourth bit aborts the word without a done pulse
      cyc(1'b0, 1'b1, 8'hC1, 1'b1, 1'b1, 6'b100000, "rst_load");
      for (int i = 0; i < 4; i++)
         cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 6'b000000, $sformatf("rst_bit%0d", i));
      cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 6'b000000, "rst_mid");
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 6'b100000, "rst_after");
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 6'b100000, "rst_nodone");

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++)
         cyc(($urandom_range(0, 39) == 0), 1'($urandom), 8'($urandom),
             ($urandom_range(0, 3) != 0), 1'b0, 6'b000000, $sformatf("rnd%0d", i));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/reg_serializer.md
Name: reg_serializer

Overview:
Parallel-to-serial unloader that reads a WIDTH-bit word from an upstream register stage and emits it one bit per accepted cycle over a valid/ready serial stream. It is the read-out end of the team's parallel load registers, and is used to stream register contents to serial links and debug taps. A single word is in flight at a time. The block reports busy while shifting and pulses done when the word has been fully consumed.

Parameters:
WIDTH, 8, word length in bits (legal: 1..64)
MSB_FIRST, 0, bit order: 0 = LSB first, 1 = MSB first

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream word available
in_ready  output  1  block can accept a word
in_data  input  WIDTH  parallel word, sampled on load
out_valid  output  1  out_bit is valid
out_ready  input  1  downstream accepts out_bit this cycle
out_bit  output  1  current serial bit
out_last  output  1  current bit is the final bit of the word
busy  output  1  word in flight (state SHIFT)
done  output  1  one-cycle pulse after the final bit is accepted

Behaviour:
- State machine with two states: IDLE and SHIFT. Internal state: shift register sreg[WIDTH-1:0] and bit counter cnt of width max(1, clog2(WIDTH)).
- Reset is synchronous. While reset is high at a clock edge: state <= IDLE, sreg <= 0, cnt <= 0, done <= 0.
- While reset is asserted, in_ready, out_valid, out_last, busy and done are all 0, and out_bit is 0.
- in_ready = (state == IDLE) && !reset. busy = (state == SHIFT). out_valid = busy.
- Load: when in_valid && in_ready at an edge: sreg <= in_data, cnt <= 0, state <= SHIFT. in_data is ignored in every other cycle.
- out_bit = sreg[0] if MSB_FIRST == 0, else sreg[WIDTH-1]. out_bit is 0 in IDLE.
- out_last = busy && (cnt == WIDTH-1).
- Transfer: a transfer occurs when out_valid && out_ready at an edge.
  - On a non-last transfer, sreg shifts toward the output end with zero fill, and cnt increments.
  - On a last transfer, state <= IDLE and done <= 1 for exactly one cycle.
- Backpressure: while out_valid && !out_ready, out_bit, out_last, sreg and cnt hold stable. There is no timeout.
- Latency:
  - The first bit is valid the cycle after the load edge.
  - With out_ready held high, a word takes WIDTH transfer cycles.
  - in_ready reasserts the cycle after the last transfer, in the same cycle as done.
  - A new word may load in the done cycle. Maximum throughput is one word per WIDTH+1 cycles.
- done is registered. It is 1 only in the cycle immediately following the last transfer and is independent of in_valid.
- WIDTH == 1: every bit is last. The word is loaded, emits one bit with out_last = 1, and then done follows.
- Reset mid-word: the word is aborted and the remaining bits are discarded. No done pulse is produced, and the block is in IDLE on the first cycle after reset deasserts.
- Counter never wraps: the SHIFT state exits at cnt == WIDTH-1 before any overflow.

Test Plan:
- WIDTH=8, MSB_FIRST=0, load 0xC1, out_ready=1 -> out_bit 1,0,0,0,0,0,1,1 on 8 consecutive cycles starting the cycle after load. out_last is high only on the 8th bit, busy is high for those 8 cycles, done pulses on cycle 9, and in_ready is 1 on cycle 9.
- MSB_FIRST=1, load 0xC1 -> out_bit 1,1,0,0,0,0,0,1, with out_last on the 8th bit.
- Backpressure: load 0xC1 (LSB first) and drop out_ready for 3 cycles after the 2nd bit -> out_bit holds 0 with out_valid=1 for those 3 cycles, the remaining sequence is unchanged, and done arrives 3 cycles later than in the unstalled case.
- Busy collision: hold in_valid=1 with in_data=0xFF during the shift of 0xC1 -> in_ready=0 throughout, output is the 0xC1 sequence, and 0xFF loads in the done cycle and is emitted next as eight 1s.
- Reset mid-word: assert reset for 1 cycle after the 4th bit of 0xC1 -> out_valid, busy, done and out_bit are 0 on the next cycle, no done pulse occurs, and in_ready=1 after reset is released.
- WIDTH=1: load 1'b1 -> a single out_bit=1 with out_last=1, then done is 1 on the following cycle.
